// File: rtl/pc_fetch_sequencer.sv
// RISC-V fetch-stage PC sequencer: owns the PC, picks the next fetch address
// and runs the req/gnt handshake with instruction memory.
module pc_fetch_sequencer #(
    parameter int unsigned   N         = 32,
    parameter logic [N-1:0]  RESET_VEC = N'(32'h0000_0000),
    parameter logic [N-1:0]  TRAP_VEC  = N'(32'h0000_0100)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         trap_valid,
    input  logic         halt_req,
    input  logic         resume,
    input  logic         imem_gnt,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] pc_plus4,
    output logic         fetch_kill,
    output logic         halted,
    output logic         misalign_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         req_hold_q, req_hold_d;
    logic         pend_valid_q, pend_valid_d;
    logic         pend_trap_q, pend_trap_d;
    logic [N-1:0] pend_target_q, pend_target_d;
    logic         halted_q, halted_d;
    logic         misalign_q, misalign_d;

    logic         redir_misaligned;
    logic         imm_trap;
    logic         imm_valid;
    logic [N-1:0] imm_target;
    logic         grant;
    logic         waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            req_hold_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_trap_q   <= 1'b0;
            pend_target_q <= RESET_VEC;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_hold_q    <= req_hold_d;
            pend_valid_q  <= pend_valid_d;
            pend_trap_q   <= pend_trap_d;
            pend_target_q <= pend_target_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    // Next-state, next-PC and handshake decode
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_hold_d    = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_trap_d   = pend_trap_q;
        pend_target_d = pend_target_q;

        redir_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
        imm_trap   = trap_valid || redir_misaligned;
        imm_valid  = imm_trap || redirect_valid;
        imm_target = imm_trap ? TRAP_VEC : redirect_target;

        pc_plus4 = pc_q + N'(4);
        imem_req = (state_q == RUN) && (req_hold_q || (!stall && !halt_req));
        grant    = imem_req && imem_gnt;
        waiting  = imem_req && !imem_gnt;
        fetch_kill = imem_gnt && (redirect_valid || trap_valid || pend_valid_q);

        if (grant) begin
            if (imm_valid) begin
                pc_d = imm_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_plus4;
            end
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
        end else if (waiting) begin
            // Address must stay stable; park redirects, traps always win
            req_hold_d = 1'b1;
            if (imm_trap) begin
                pend_valid_d  = 1'b1;
                pend_trap_d   = 1'b1;
                pend_target_d = TRAP_VEC;
            end else if (redirect_valid && !pend_trap_q) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redirect_target;
            end
        end else if (imm_valid) begin
            pc_d = imm_target;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req && !waiting) state_d = HALTED;
            HALTED:  if (resume) state_d = RUN;
            default: state_d = BOOT;
        endcase

        halted_d   = (state_d == HALTED);
        misalign_d = redir_misaligned;
    end

    assign imem_addr    = pc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule
